// File: rtl/sdrc_define.sv
// Shared SDRAM-controller definitions: request widths, address field widths
// and the request-splitter state encoding.
package sdrc_define;

   localparam int REQ_BW       = 12;
   localparam int SDR_REQ_ID_W = 4;
   localparam int COL_W        = 11;
   localparam int ROW_W        = 13;

   typedef enum logic {
      REQS_IDLE  = 1'b0,
      REQS_ISSUE = 1'b1
   } reqState_t;

   // Column-address width selected by the 2-bit configuration code (8..11 bits).
   function automatic logic [3:0] colWidth(input logic [1:0] cfg);
      return 4'd8 + {2'b00, cfg};
   endfunction

endpackage

// File: rtl/sdrc_chunk_calc.sv
// Chunk sizing: the largest piece of the remaining request that stays inside
// the current column page and within the per-chunk word cap.
module sdrc_chunk_calc
   import sdrc_define::*;
#(
   parameter int MAX_CHUNK = 16
) (
   input  logic [1:0]        colbits_i,
   input  logic [COL_W-1:0]  col_i,
   input  logic [REQ_BW-1:0] rem_i,
   input  logic              wrap_i,
   output logic [REQ_BW-1:0] len_o
);

   localparam int CW = REQ_BW + 1;

   logic [CW-1:0] pageSize;
   logic [CW-1:0] pageRem;
   logic [CW-1:0] limit;
   logic [CW-1:0] remWide;

   // Wrap bursts go out whole; everything else is clipped to the page end and the cap.
   always_comb begin
      pageSize = CW'(1) << colWidth(colbits_i);
      pageRem  = pageSize - CW'(col_i);
      limit    = (pageRem < CW'(MAX_CHUNK)) ? pageRem : CW'(MAX_CHUNK);
      remWide  = CW'(rem_i);
      if (wrap_i || (remWide <= limit)) begin
         len_o = rem_i;
      end else begin
         len_o = REQ_BW'(limit);
      end
   end

endmodule

// File: rtl/sdrc_req_split.sv
// Request splitter: breaks one linear application request into page- and
// size-bounded chunks for the bank FSM, one request in flight at a time.
module sdrc_req_split
   import sdrc_define::*;
#(
   parameter int APP_AW    = 26,
   parameter int MAX_CHUNK = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              cfg_colbits,
   input  logic                    app_req,
   input  logic [APP_AW-1:0]       app_req_addr,
   input  logic [REQ_BW-1:0]       app_req_len,
   input  logic                    app_req_wr,
   input  logic                    app_req_wrap,
   input  logic [SDR_REQ_ID_W-1:0] app_req_id,
   input  logic                    app_req_dma_last,
   output logic                    app_req_ack,
   output logic                    r2b_req,
   output logic                    r2b_start,
   output logic                    r2b_last,
   output logic                    r2b_wrap,
   output logic                    r2b_write,
   output logic [SDR_REQ_ID_W-1:0] r2b_req_id,
   output logic [1:0]              r2b_ba,
   output logic [12:0]             r2b_raddr,
   output logic [12:0]             r2b_caddr,
   output logic [REQ_BW-1:0]       r2b_len,
   output logic                    sdr_dma_last,
   input  logic                    b2r_ack,
   output logic                    busy
);

   reqState_t         state_q;
   logic [APP_AW-1:0] addr_q;
   logic [APP_AW-1:0] addr_d;
   logic [REQ_BW-1:0] rem_q;
   logic [REQ_BW-1:0] rem_d;
   logic [REQ_BW-1:0] len_d;
   logic              wrap_d;
   logic              dmaLast_q;
   logic              dmaSel;
   logic [3:0]        colBits;
   logic [COL_W-1:0]  col_d;
   logic [1:0]        bank_d;
   logic [ROW_W-1:0]  row_d;
   logic              capture;
   logic              advance;
   logic              finish;
   logic              lastChunk;

   assign app_req_ack = ~reset & app_req & (state_q == REQS_IDLE);
   assign capture     = app_req_ack & (app_req_len != '0);
   assign advance     = (state_q == REQS_ISSUE) & b2r_ack & ~r2b_last;
   assign finish      = (state_q == REQS_ISSUE) & b2r_ack & r2b_last;
   assign busy        = (state_q != REQS_IDLE);
   assign lastChunk   = (len_d == rem_d);

   // The next chunk starts either at a freshly captured request or just past the
   // chunk being acknowledged; its address is decoded here so the outputs can be registered.
   always_comb begin
      if (state_q == REQS_IDLE) begin
         addr_d = app_req_addr;
         rem_d  = app_req_len;
         wrap_d = app_req_wrap;
         dmaSel = app_req_dma_last;
      end else begin
         addr_d = addr_q + APP_AW'(r2b_len);
         rem_d  = rem_q - r2b_len;
         wrap_d = r2b_wrap;
         dmaSel = dmaLast_q;
      end
      colBits = colWidth(cfg_colbits);
      col_d   = COL_W'(addr_d & ((APP_AW'(1) << colBits) - APP_AW'(1)));
      bank_d  = 2'(addr_d >> colBits);
      row_d   = ROW_W'(addr_d >> (colBits + 4'd2));
   end

   sdrc_chunk_calc #(
      .MAX_CHUNK (MAX_CHUNK)
   ) uChunkCalc (
      .colbits_i (cfg_colbits),
      .col_i     (col_d),
      .rem_i     (rem_d),
      .wrap_i    (wrap_d),
      .len_o     (len_d)
   );

   // IDLE -> ISSUE on a non-empty capture; each non-final ack reloads the next
   // chunk with r2b_req held high, the final ack returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= REQS_IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         dmaLast_q    <= 1'b0;
         r2b_req      <= 1'b0;
         r2b_start    <= 1'b0;
         r2b_last     <= 1'b0;
         r2b_wrap     <= 1'b0;
         r2b_write    <= 1'b0;
         r2b_req_id   <= '0;
         r2b_ba       <= '0;
         r2b_raddr    <= '0;
         r2b_caddr    <= '0;
         r2b_len      <= '0;
         sdr_dma_last <= 1'b0;
      end else if (capture || advance) begin
         state_q      <= REQS_ISSUE;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         r2b_req      <= 1'b1;
         r2b_start    <= capture;
         r2b_last     <= lastChunk;
         sdr_dma_last <= dmaSel & lastChunk;
         r2b_ba       <= bank_d;
         r2b_raddr    <= row_d;
         r2b_caddr    <= 13'(col_d);
         r2b_len      <= len_d;
         if (capture) begin
            r2b_wrap   <= app_req_wrap;
            r2b_write  <= app_req_wr;
            r2b_req_id <= app_req_id;
            dmaLast_q  <= app_req_dma_last;
         end
      end else if (finish) begin
         state_q      <= REQS_IDLE;
         r2b_req      <= 1'b0;
         r2b_start    <= 1'b0;
         r2b_last     <= 1'b0;
         sdr_dma_last <= 1'b0;
      end
   end

endmodule
